// File: rtl/offset_button_ctrl_pkg.sv
// Shared constants, FSM encoding and direction priority for the offset button controller.
package offset_button_ctrl_pkg;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefPulseCycles    = 4;
  localparam int unsigned DefRepeatDelay    = 12500000;
  localparam int unsigned DefRepeatPeriod   = 2500000;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StGap
  } state_e;

  // Up > Down > Left > Right; caller guarantees at least one bit is set.
  function automatic logic [1:0] pick_dir(input logic [3:0] btn);
    logic [1:0] dir;
    dir = 2'(DIR_RIGHT);
    if (btn[DIR_LEFT])  dir = 2'(DIR_LEFT);
    if (btn[DIR_DOWN])  dir = 2'(DIR_DOWN);
    if (btn[DIR_UP])    dir = 2'(DIR_UP);
    return dir;
  endfunction

endpackage

// File: rtl/offset_button_ctrl_button_debouncer.sv
// One-bit button conditioner: 2-flop synchroniser followed by a stable-count debouncer.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_deb
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign btn_deb = deb_q;

endmodule

// File: rtl/offset_button_ctrl.sv
// Turns four raw push-buttons into registered one-hot move pulses with auto-repeat.
module offset_button_ctrl
  import offset_button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned PULSE_CYCLES    = DefPulseCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btnRaw,
  output logic [3:0] OffsetFlag,
  output logic       busy
);

  localparam int unsigned PulseW = $clog2(PULSE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TimerW = $clog2(RepMax + 1);

  logic [3:0] btn_deb;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btnRaw[i]),
      .btn_deb(btn_deb[i])
    );
  end

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic                first_q, first_d;
  logic [PulseW-1:0]   pcnt_q, pcnt_d;
  logic [TimerW-1:0]   tcnt_q, tcnt_d;
  logic [TimerW-1:0]   gap_last;
  logic [3:0]          flag_q, flag_d;

  assign gap_last = first_q ? TimerW'(REPEAT_DELAY - 1) : TimerW'(REPEAT_PERIOD - 1);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    first_d = first_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (|btn_deb) begin
          dir_d   = pick_dir(btn_deb);
          first_d = 1'b1;
          pcnt_d  = '0;
          state_d = StFire;
        end
      end
      StFire: begin
        // A release here is deliberately ignored so the pulse is never truncated.
        if (pcnt_q == PulseW'(PULSE_CYCLES - 1)) begin
          pcnt_d  = '0;
          tcnt_d  = '0;
          state_d = StGap;
        end else begin
          pcnt_d = pcnt_q + PulseW'(1);
        end
      end
      StGap: begin
        if (!btn_deb[dir_q]) begin
          tcnt_d  = '0;
          state_d = StIdle;
        end else if (tcnt_q == gap_last) begin
          first_d = 1'b0;
          tcnt_d  = '0;
          pcnt_d  = '0;
          state_d = StFire;
        end else begin
          tcnt_d = tcnt_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Output is registered from the next state so the flag rises with FIRE entry.
    flag_d = (state_d == StFire) ? (4'b0001 << dir_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= '0;
      first_q <= 1'b1;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      flag_q  <= flag_d;
    end
  end

  assign OffsetFlag = flag_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_offset_button_ctrl.sv
// Directed bench for offset_button_ctrl with shortened timing constants.
module tb_offset_button_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btnRaw;
  logic [3:0] OffsetFlag;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  offset_button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btnRaw    (btnRaw),
    .OffsetFlag(OffsetFlag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Leaves time just after an edge with reset low; the next posedge is edge 0.
  task automatic do_reset();
    reset  = 1'b1;
    btnRaw = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btnRaw = 4'b1111;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (OffsetFlag !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_flag cycle %0d: got %b want 0000", e, OffsetFlag);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy cycle %0d: got %b want 0", e, busy);
      end
    end
  endtask

  task automatic test_single_tap();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 25; e++) begin
      btnRaw = (e < 10) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
      ef = (e == 6 || e == 7) ? 4'b0001 : 4'b0000;
      eb = (e >= 6 && e <= 15);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL single_tap_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL single_tap_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 0; e < 40; e++) begin
      btnRaw = (((e / 2) % 2) == 0) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      vectors++;
      if (OffsetFlag !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce_flag edge %0d: got %b want 0000", e, OffsetFlag);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_busy edge %0d: got %b want 0", e, busy);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 95; e++) begin
      btnRaw = (e < 80) ? 4'b0100 : 4'b0000;
      @(posedge clk);
      #1;
      // Rises at 6, then 28 and every 10 after while held.
      ef = ((e == 6 || e == 7) || (e >= 28 && e < 80 && ((e - 28) % 10) < 2)) ?
           4'b0100 : 4'b0000;
      eb = (e >= 6 && e <= 85);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL auto_repeat_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL auto_repeat_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
  endtask

  task automatic test_priority_opposite();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 45; e++) begin
      btnRaw = (e < 10) ? 4'b0011 : ((e < 30) ? 4'b0010 : 4'b0000);
      @(posedge clk);
      #1;
      if (e == 6 || e == 7)        ef = 4'b0001;
      else if (e == 17 || e == 18) ef = 4'b0010;
      else                         ef = 4'b0000;
      eb = (e >= 6 && e <= 15) || (e >= 17 && e <= 35);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL priority_ud_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL priority_ud_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
  endtask

  task automatic test_priority_left_right();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 25; e++) begin
      btnRaw = (e < 10) ? 4'b1100 : 4'b0000;
      @(posedge clk);
      #1;
      ef = (e == 6 || e == 7) ? 4'b0100 : 4'b0000;
      eb = (e >= 6 && e <= 15);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL priority_lr_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL priority_lr_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
  endtask

  task automatic test_release_in_fire();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 25; e++) begin
      btnRaw = (e < 7) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      ef = (e == 6 || e == 7) ? 4'b1000 : 4'b0000;
      eb = (e >= 6 && e <= 12);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL release_fire_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL release_fire_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [3:0] ef;
    logic       eb;
    do_reset();
    for (int e = 0; e < 21; e++) begin
      btnRaw = 4'b1000;
      reset  = (e == 7);
      @(posedge clk);
      #1;
      ef = (e == 6 || e == 14 || e == 15) ? 4'b1000 : 4'b0000;
      eb = (e == 6) || (e >= 14);
      vectors++;
      if (OffsetFlag !== ef) begin
        miscompares++;
        $display("FAIL reset_mid_flag edge %0d: got %b want %b", e, OffsetFlag, ef);
      end
      vectors++;
      if (busy !== eb) begin
        miscompares++;
        $display("FAIL reset_mid_busy edge %0d: got %b want %b", e, busy, eb);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    btnRaw = 4'b0000;
    test_reset();
    test_single_tap();
    test_bounce();
    test_auto_repeat();
    test_priority_opposite();
    test_priority_left_right();
    test_release_in_fire();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
